// File: rtl/silife_pkg.sv
`default_nettype none
// ============================================================================
// Module      : silife_pkg
// Description : Shared definitions for the SiLife generation sequencer.
//               Holds the sequencer FSM state encoding, the default grid
//               geometry and the generation counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package silife_pkg;

    // Default grid geometry: 32 rows of 32 cells, 5-bit row address
    localparam int c_def_rows   = 32;
    localparam int c_def_addr_w = 5;
    localparam int c_def_data_w = 32;

    // Width of the generation counter reported on gen_count
    localparam int c_gen_cnt_w  = 16;

    // Sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SWEEP = 3'd2,
        ST_HOST  = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

endpackage : silife_pkg
`default_nettype wire

// File: rtl/silife_period_timer.sv
`default_nettype none
// ============================================================================
// Module      : silife_period_timer
// Description : Down-counter that paces free-running generations.
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (count forced to 0)
//   i_load     in   load the count from i_period (period sampled only here)
//   i_clear    in   force the count to 0
//   i_run      in   decrement by one per cycle while non-zero
//   i_period   in   reload value
//   o_expired  out  count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module silife_period_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic                i_clear,
    input  logic                i_run,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_expired
);

    logic [PERIOD_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_period;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule : silife_period_timer
`default_nettype wire

// File: rtl/silife_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : silife_sequencer
// Description : Generation sequencer for the SiLife cell grid. Sweeps the
//               grid rows one per cycle to evolve a generation (free-running
//               with a programmable gap, or single-stepped), and arbitrates
//               host row read/write accesses against the sweep.
//   clk, rst_n             clock, asynchronous active-low reset
//   enable, step, period   free-run enable, single-step pulse, gap length
//   host_req/we/addr/wdata host access request (held until host_ack)
//   host_ack, host_rdata   access completion and read data
//   grid_addr/we/wdata     grid row port; grid_rdata returns one cycle later
//   evolve_en              grid commits next state of row grid_addr
//   busy, gen_done, gen_count  status
// Revision    : 1.0 - initial release
// ============================================================================
module silife_sequencer
    import silife_pkg::*;
#(
    parameter int ROWS     = c_def_rows,
    parameter int ADDR_W   = c_def_addr_w,
    parameter int DATA_W   = c_def_data_w,
    parameter int PERIOD_W = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   step,
    input  logic [PERIOD_W-1:0]    period,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [ADDR_W-1:0]      host_addr,
    input  logic [DATA_W-1:0]      host_wdata,
    output logic                   host_ack,
    output logic [DATA_W-1:0]      host_rdata,
    output logic [ADDR_W-1:0]      grid_addr,
    output logic                   grid_we,
    output logic [DATA_W-1:0]      grid_wdata,
    input  logic [DATA_W-1:0]      grid_rdata,
    output logic                   evolve_en,
    output logic                   busy,
    output logic                   gen_done,
    output logic [c_gen_cnt_w-1:0] gen_count
);

    // ROWS must fit in the row address (ROWS <= 2**ADDR_W)
    localparam logic [ADDR_W-1:0] c_last_row = ADDR_W'(ROWS - 1);

    state_e                 r_state;
    logic [ADDR_W-1:0]      r_row;
    logic                   r_tail;       // SWEEP tail cycle: gen_done slot
    logic                   r_pending;    // sweep displaced by a host access
    logic                   r_ret_wait;   // host access interrupted WAIT
    logic [c_gen_cnt_w-1:0] r_gen_count;

    logic w_expired;
    logic w_tmr_load;
    logic w_tmr_clear;
    logic w_tmr_run;

    // Timer is reloaded on entry to WAIT (from IDLE or from the sweep tail),
    // cleared when enable drops in WAIT, and frozen whenever a host access
    // is accepted or in flight.
    assign w_tmr_load  = ((r_state == ST_IDLE) && !host_req && enable) ||
                         ((r_state == ST_SWEEP) && r_tail && enable);
    assign w_tmr_clear = (r_state == ST_WAIT) && !host_req && !enable;
    assign w_tmr_run   = (r_state == ST_WAIT) && !host_req;

    silife_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_tmr_load),
        .i_clear   (w_tmr_clear),
        .i_run     (w_tmr_run),
        .i_period  (period),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_tail      <= 1'b0;
            r_pending   <= 1'b0;
            r_ret_wait  <= 1'b0;
            r_gen_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Host wins a same-cycle conflict; a coincident step is
                    // remembered and run straight after the access.
                    if (host_req) begin
                        r_state    <= ST_HOST;
                        r_ret_wait <= 1'b0;
                        r_pending  <= step && !enable;
                    end else if (enable) begin
                        r_state <= ST_WAIT;
                    end else if (step) begin
                        r_state <= ST_SWEEP;
                    end
                end
                ST_WAIT: begin
                    if (host_req) begin
                        r_state    <= ST_HOST;
                        r_ret_wait <= 1'b1;
                        r_pending  <= w_expired && enable;
                    end else if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_expired) begin
                        r_state <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    // ROWS evolve cycles followed by one tail cycle that
                    // reports the completed generation.
                    if (r_tail) begin
                        r_tail      <= 1'b0;
                        r_row       <= '0;
                        r_gen_count <= r_gen_count + 1'b1;
                        r_state     <= enable ? ST_WAIT : ST_IDLE;
                    end else if (r_row == c_last_row) begin
                        r_tail <= 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                ST_HOST: begin
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    if (r_pending) begin
                        r_pending <= 1'b0;
                        r_state   <= ST_SWEEP;
                    end else if (r_ret_wait) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state so an asynchronous reset clears
    // them in the same instant.
    assign evolve_en  = (r_state == ST_SWEEP) && !r_tail;
    assign gen_done   = (r_state == ST_SWEEP) && r_tail;
    assign busy       = (r_state == ST_SWEEP) || (r_state == ST_HOST) ||
                        (r_state == ST_ACK);
    assign grid_addr  = (r_state == ST_HOST) ? host_addr : r_row;
    assign grid_we    = (r_state == ST_HOST) && host_we;
    assign grid_wdata = (r_state == ST_HOST) ? host_wdata : '0;
    assign host_ack   = (r_state == ST_ACK);
    // Host holds its operands through ACK, so host_we still qualifies reads
    assign host_rdata = ((r_state == ST_ACK) && !host_we) ? grid_rdata : '0;
    assign gen_count  = r_gen_count;

endmodule : silife_sequencer
`default_nettype wire
